// File: rtl/and_result_pkg.sv
//------------------------------------------------------------------------------
// Module   : and_result_pkg
// Purpose  : Shared types, defaults and helpers for the AND result responder.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package and_result_pkg;

  // Occupancy of the result buffer
  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    PARTIAL = 2'd1,
    FULL    = 2'd2
  } and_occ_state_t;

  localparam int AND_INPUTS_WIDTH_DEFAULT = 8;

  // Even parity (XOR reduction) of a zero-extended value; zero padding leaves
  // the result unchanged, so callers may pass any width up to 64 bits.
  function automatic logic par_of(input logic [63:0] v);
    return ^v;
  endfunction

endpackage

`default_nettype wire

// File: rtl/and_result_fifo.sv
//------------------------------------------------------------------------------
// Module   : and_result_fifo
// Purpose  : First-word-fall-through buffer with occupancy FSM, pointers and
//            level count. Data width is generic; depth must be a power of two
//            and at least 2 so the pointers wrap naturally.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module and_result_fifo
  import and_result_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_valid,
  output logic                       push_ready,
  input  logic [DATA_W-1:0]          push_data,
  output logic                       pop_valid,
  input  logic                       pop_ready,
  output logic [DATA_W-1:0]          pop_data,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  and_occ_state_t          state, state_nxt;
  logic [PTR_W-1:0]        wr_ptr, rd_ptr;
  logic [LVL_W-1:0]        lvl;
  logic [DATA_W-1:0]       mem [DEPTH];
  logic                    push, pop;

  // Handshake flags come from registered state only, so push_ready has no
  // combinational path from pop_ready; a push while FULL is simply refused.
  assign push_ready = (state != FULL);
  assign pop_valid  = (state != EMPTY);
  assign push       = push_valid && push_ready;
  assign pop        = pop_valid && pop_ready;
  assign level      = lvl;
  assign pop_data   = (state == EMPTY) ? '0 : mem[rd_ptr];

  // Occupancy state register
  always_ff @(posedge clk) begin
    if (rst) state <= EMPTY;
    else     state <= state_nxt;
  end

  // Next-state decode driven by push/pop and the current level
  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY:   if (push) state_nxt = PARTIAL;
      PARTIAL: begin
        if (push && !pop && (lvl == LVL_W'(DEPTH - 1)))
          state_nxt = FULL;
        else if (pop && !push && (lvl == LVL_W'(1)))
          state_nxt = EMPTY;
      end
      FULL:    if (pop) state_nxt = PARTIAL;
      default: state_nxt = EMPTY;
    endcase
  end

  // Pointer and level bookkeeping; simultaneous push and pop keep the level
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      lvl    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)      lvl <= lvl + LVL_W'(1);
      else if (pop && !push) lvl <= lvl - LVL_W'(1);
    end
  end

  // Storage write; contents need no reset because reads are masked while EMPTY
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

endmodule

`default_nettype wire

// File: rtl/and_result_responder.sv
//------------------------------------------------------------------------------
// Module   : and_result_responder
// Purpose  : Accepts operand pairs over valid/ready, buffers a & b in a FWFT
//            FIFO, presents results over a second valid/ready handshake and
//            counts accepted pairs.
// Options  : AND_RESP_PARITY_EN - adds out_par (= ^out_y) stored with each
//            buffered result.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module and_result_responder
  import and_result_pkg::*;
#(
  parameter int AND_INPUTS_WIDTH = AND_INPUTS_WIDTH_DEFAULT,
  parameter int FIFO_DEPTH       = 4,
  parameter int CNT_WIDTH        = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [AND_INPUTS_WIDTH-1:0]   a,
  input  logic [AND_INPUTS_WIDTH-1:0]   b,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [AND_INPUTS_WIDTH-1:0]   out_y,
`ifdef AND_RESP_PARITY_EN
  output logic                          out_par,
`endif
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic [CNT_WIDTH-1:0]          txn_count
);

`ifdef AND_RESP_PARITY_EN
  localparam int ENTRY_W = AND_INPUTS_WIDTH + 1;
`else
  localparam int ENTRY_W = AND_INPUTS_WIDTH;
`endif

  logic [AND_INPUTS_WIDTH-1:0] y_in;
  logic [ENTRY_W-1:0]          wr_entry;
  logic [ENTRY_W-1:0]          rd_entry;
  logic                        accept;

  // Operands are only consumed on accept, so undriven bus values are harmless
  assign y_in   = a & b;
  assign accept = in_valid && in_ready;

`ifdef AND_RESP_PARITY_EN
  // Parity is computed once at write time and travels with the entry
  assign wr_entry = {par_of(64'(y_in)), y_in};
  assign out_par  = rd_entry[AND_INPUTS_WIDTH];
`else
  assign wr_entry = y_in;
`endif
  assign out_y = rd_entry[AND_INPUTS_WIDTH-1:0];

  and_result_fifo #(
    .DATA_W (ENTRY_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_valid (in_valid),
    .push_ready (in_ready),
    .push_data  (wr_entry),
    .pop_valid  (out_valid),
    .pop_ready  (out_ready),
    .pop_data   (rd_entry),
    .level      (level)
  );

  // Accepted-transaction counter, wraps freely
  always_ff @(posedge clk) begin
    if (rst)         txn_count <= '0;
    else if (accept) txn_count <= txn_count + CNT_WIDTH'(1);
  end

endmodule

`default_nettype wire
